// File: rtl/ddfs_sweep_ctrl_if.sv
// Sweep configuration/status bundle between the config source and the FTW scheduler.
// Master drives the sweep request and config; slave returns the tuning word and status strobes.
interface ddfs_sweep_ctrl_if #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [1:0]         mode;
  logic [FTW_W-1:0]   ftw_start;
  logic [FTW_W-1:0]   ftw_stop;
  logic [FTW_W-1:0]   ftw_step;
  logic [DWELL_W-1:0] dwell;

  logic [FTW_W-1:0]   ftw_out;
  logic               ftw_load;
  logic               busy;
  logic               done;
  logic               wrap;
  logic               dir;

  modport master (
    output start, abort, mode, ftw_start, ftw_stop, ftw_step, dwell,
    input  ftw_out, ftw_load, busy, done, wrap, dir
  );

  modport slave (
    input  start, abort, mode, ftw_start, ftw_stop, ftw_step, dwell,
    output ftw_out, ftw_load, busy, done, wrap, dir
  );
endinterface

// File: rtl/ddfs_sweep_ctrl.sv
// Stepped linear FTW chirp scheduler: single, sawtooth and triangle sweeps with dwell per point.
// First point one cycle after start; no backpressure, start ignored while busy, abort wins over start.
module ddfs_sweep_ctrl #(
  parameter int FTW_W   = 32,
  parameter int DWELL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  ddfs_sweep_ctrl_if.slave  bus
);

  localparam logic [1:0] MODE_CONT = 2'd1;
  localparam logic [1:0] MODE_UPDN = 2'd2;

  // The STEP decision is folded into the last dwell cycle, so it never occupies an output cycle.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [1:0]         r_mode,   w_mode_nxt;
  logic [FTW_W-1:0]   r_start,  w_start_nxt;
  logic [FTW_W-1:0]   r_stop,   w_stop_nxt;
  logic [FTW_W-1:0]   r_step,   w_step_nxt;
  logic [DWELL_W-1:0] r_dwell,  w_dwell_nxt;
  logic [DWELL_W-1:0] r_cnt,    w_cnt_nxt;
  logic [FTW_W-1:0]   r_ftw,    w_ftw_nxt;
  logic               r_load,   w_load_nxt;
  logic               r_done,   w_done_nxt;
  logic               r_wrap,   w_wrap_nxt;
  logic               r_dir,    w_dir_nxt;
  logic               r_end,    w_end_nxt;
  logic               r_degen,  w_degen_nxt;

  logic [FTW_W:0]     w_asc_sum;
  logic [FTW_W:0]     w_dsc_diff;
  logic               w_asc_top;
  logic               w_dsc_bot;
  logic [FTW_W-1:0]   w_asc_next;
  logic [FTW_W-1:0]   w_dsc_next;

  // r_end marks the endpoint in the current direction: top while ascending, bottom while descending.
  assign w_asc_sum  = {1'b0, r_ftw} + {1'b0, r_step};
  assign w_asc_top  = (w_asc_sum >= {1'b0, r_stop});
  assign w_asc_next = w_asc_top ? r_stop : w_asc_sum[FTW_W-1:0];
  assign w_dsc_diff = {1'b0, r_ftw} - {1'b0, r_step};
  assign w_dsc_bot  = w_dsc_diff[FTW_W] || (w_dsc_diff[FTW_W-1:0] <= r_start);
  assign w_dsc_next = w_dsc_bot ? r_start : w_dsc_diff[FTW_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_start_nxt = r_start;
    w_stop_nxt  = r_stop;
    w_step_nxt  = r_step;
    w_dwell_nxt = r_dwell;
    w_cnt_nxt   = r_cnt;
    w_ftw_nxt   = r_ftw;
    w_dir_nxt   = r_dir;
    w_end_nxt   = r_end;
    w_degen_nxt = r_degen;
    w_load_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = S_DWELL;
          w_mode_nxt  = bus.mode;
          w_start_nxt = bus.ftw_start;
          w_stop_nxt  = bus.ftw_stop;
          w_step_nxt  = bus.ftw_step;
          w_dwell_nxt = bus.dwell;
          w_degen_nxt = (bus.ftw_start >= bus.ftw_stop) || (bus.ftw_step == '0);
          w_ftw_nxt   = bus.ftw_start;
          w_cnt_nxt   = '0;
          w_dir_nxt   = 1'b0;
          w_end_nxt   = 1'b0;
          w_load_nxt  = 1'b1;
        end
      end

      S_DWELL: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_dir_nxt   = 1'b0;
        end else if (r_cnt != r_dwell) begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end else begin
          w_cnt_nxt  = '0;
          w_load_nxt = 1'b1;
          if (r_degen || (!r_dir && r_end && r_mode != MODE_CONT && r_mode != MODE_UPDN)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_load_nxt  = 1'b0;
            w_dir_nxt   = 1'b0;
          end else if (!r_dir && r_end && r_mode == MODE_CONT) begin
            w_ftw_nxt  = r_start;
            w_end_nxt  = 1'b0;
            w_wrap_nxt = 1'b1;
          end else if (!r_dir && r_end) begin
            // Turn at the top: the first descending point is stop-step, stop is not repeated.
            w_dir_nxt  = 1'b1;
            w_wrap_nxt = 1'b1;
            w_ftw_nxt  = w_dsc_next;
            w_end_nxt  = w_dsc_bot;
          end else if (r_dir && r_end) begin
            w_dir_nxt  = 1'b0;
            w_wrap_nxt = 1'b1;
            w_ftw_nxt  = w_asc_next;
            w_end_nxt  = w_asc_top;
          end else if (r_dir) begin
            w_ftw_nxt = w_dsc_next;
            w_end_nxt = w_dsc_bot;
          end else begin
            w_ftw_nxt = w_asc_next;
            w_end_nxt = w_asc_top;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_start <= '0;
      r_stop  <= '0;
      r_step  <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_ftw   <= '0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_dir   <= 1'b0;
      r_end   <= 1'b0;
      r_degen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_start <= w_start_nxt;
      r_stop  <= w_stop_nxt;
      r_step  <= w_step_nxt;
      r_dwell <= w_dwell_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ftw   <= w_ftw_nxt;
      r_load  <= w_load_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
      r_dir   <= w_dir_nxt;
      r_end   <= w_end_nxt;
      r_degen <= w_degen_nxt;
    end
  end

  assign bus.ftw_out  = r_ftw;
  assign bus.ftw_load = r_load;
  assign bus.busy     = (r_state == S_DWELL);
  assign bus.done     = r_done;
  assign bus.wrap     = r_wrap;
  assign bus.dir      = r_dir;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Directed bench for ddfs_sweep_ctrl: per-cycle expected outputs are queued, then popped and compared.
module tb_ddfs_sweep_ctrl;
  localparam int FTW_W   = 32;
  localparam int DWELL_W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ddfs_sweep_ctrl_if #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) bus ();

  ddfs_sweep_ctrl #(.FTW_W(FTW_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FTW_W-1:0] ftw;
    logic             load;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             dir;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input logic [FTW_W-1:0] f, input logic l, input logic b,
                      input logic d, input logic w, input logic r);
    obs_t e;
    e.ftw = f; e.load = l; e.busy = b; e.done = d; e.wrap = w; e.dir = r;
    exp_q.push_back(e);
  endtask

  // One sweep point: dwell+1 busy cycles, load and wrap only in the first.
  task automatic pt(input logic [FTW_W-1:0] f, input int dw, input logic r, input logic w);
    for (int i = 0; i <= dw; i++)
      push(f, (i == 0), 1'b1, 1'b0, (i == 0) ? w : 1'b0, r);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag);
    obs_t o;
    obs_t e;
    o = {bus.ftw_out, bus.ftw_load, bus.busy, bus.done, bus.wrap, bus.dir};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed ftw=%h load=%b busy=%b done=%b wrap=%b dir=%b, expected nothing queued",
             tag, o.ftw, o.load, o.busy, o.done, o.wrap, o.dir);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed ftw=%h load=%b busy=%b done=%b wrap=%b dir=%b, expected ftw=%h load=%b busy=%b done=%b wrap=%b dir=%b",
               tag, o.ftw, o.load, o.busy, o.done, o.wrap, o.dir,
               e.ftw, e.load, e.busy, e.done, e.wrap, e.dir);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      tick();
      chk(tag);
    end
  endtask

  task automatic launch(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk(tag);
  endtask

  task automatic cfg(input logic [FTW_W-1:0] s, input logic [FTW_W-1:0] e,
                     input logic [FTW_W-1:0] st, input logic [DWELL_W-1:0] dw, input logic [1:0] m);
    bus.ftw_start = s;
    bus.ftw_stop  = e;
    bus.ftw_step  = st;
    bus.dwell     = dw;
    bus.mode      = m;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(32'd7, 32'd9, 32'd1, 16'd0, 2'd0);
    bus.start = 1'b1;
    tick();
    tick();
    push('0, 0, 0, 0, 0, 0);
    chk("reset_held");
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    push('0, 0, 0, 0, 0, 0);
    chk("idle_after_reset");

    // Single sweep; mid-sweep input changes and a second start must not disturb it.
    cfg(32'd0, 32'd10, 32'd4, 16'd1, 2'd0);
    pt(32'd0, 1, 0, 0); pt(32'd4, 1, 0, 0); pt(32'd8, 1, 0, 0); pt(32'd10, 1, 0, 0);
    push(32'd10, 0, 0, 1, 0, 0);
    push(32'd10, 0, 0, 0, 0, 0);
    launch("single");
    cfg(32'd0, 32'd100, 32'd1, 16'd5, 2'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("single_busy_start");
    drain("single");

    // Continuous sawtooth, then abort together with start.
    cfg(32'd0, 32'd8, 32'd4, 16'd0, 2'd1);
    pt(32'd0, 0, 0, 0); pt(32'd4, 0, 0, 0); pt(32'd8, 0, 0, 0);
    pt(32'd0, 0, 0, 1); pt(32'd4, 0, 0, 0); pt(32'd8, 0, 0, 0);
    pt(32'd0, 0, 0, 1);
    launch("cont");
    drain("cont");
    bus.abort = 1'b1;
    bus.start = 1'b1;
    push(32'd0, 0, 0, 0, 0, 0);
    tick();
    chk("cont_abort");
    push(32'd0, 0, 0, 0, 0, 0);
    tick();
    chk("abort_blocks_start");
    bus.abort = 1'b0;
    bus.start = 1'b0;

    // Up-down triangle, then reset mid-sweep.
    cfg(32'd0, 32'd8, 32'd4, 16'd0, 2'd2);
    pt(32'd0, 0, 0, 0); pt(32'd4, 0, 0, 0); pt(32'd8, 0, 0, 0);
    pt(32'd4, 0, 1, 1); pt(32'd0, 0, 1, 0); pt(32'd4, 0, 0, 1);
    pt(32'd8, 0, 0, 0); pt(32'd4, 0, 1, 1);
    launch("updown");
    drain("updown");
    reset = 1'b1;
    push('0, 0, 0, 0, 0, 0);
    tick();
    chk("reset_mid");
    reset = 1'b0;

    // Up-down with saturation at both ends, aborted while descending.
    cfg(32'd3, 32'd10, 32'd5, 16'd1, 2'd2);
    pt(32'd3, 1, 0, 0); pt(32'd8, 1, 0, 0); pt(32'd10, 1, 0, 0);
    pt(32'd5, 1, 1, 1); pt(32'd3, 1, 1, 0);
    launch("updown_sat");
    drain("updown_sat");
    bus.abort = 1'b1;
    push(32'd3, 0, 0, 0, 0, 0);
    tick();
    chk("abort_dir");
    bus.abort = 1'b0;
    push(32'd3, 0, 0, 0, 0, 0);
    tick();
    chk("abort_idle");

    // Carry-out saturation at the top of the FTW range.
    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2'd0);
    pt(32'hFFFF_FFF0, 0, 0, 0); pt(32'hFFFF_FFFF, 0, 0, 0);
    push(32'hFFFF_FFFF, 0, 0, 1, 0, 0);
    launch("overflow");
    drain("overflow");
    cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2'd1);
    pt(32'hFFFF_FFF0, 0, 0, 0); pt(32'hFFFF_FFFF, 0, 0, 0); pt(32'hFFFF_FFF0, 0, 0, 1);
    launch("overflow_cont");
    drain("overflow_cont");
    bus.abort = 1'b1;
    push(32'hFFFF_FFF0, 0, 0, 0, 0, 0);
    tick();
    chk("overflow_abort");
    bus.abort = 1'b0;

    // Degenerate configs in every mode; each restart lands in the previous done cycle.
    for (int m = 0; m < 4; m++) begin
      cfg(32'd5, 32'd5, 32'd1, 16'd3, m[1:0]);
      pt(32'd5, 3, 0, 0);
      push(32'd5, 0, 0, 1, 0, 0);
      launch("degen_eq");
      drain("degen_eq");
    end
    cfg(32'd2, 32'd9, 32'd0, 16'd0, 2'd2);
    pt(32'd2, 0, 0, 0);
    push(32'd2, 0, 0, 1, 0, 0);
    launch("degen_step0");
    drain("degen_step0");
    cfg(32'd9, 32'd2, 32'd1, 16'd0, 2'd1);
    pt(32'd9, 0, 0, 0);
    push(32'd9, 0, 0, 1, 0, 0);
    push(32'd9, 0, 0, 0, 0, 0);
    launch("degen_rev");
    drain("degen_rev");

    // Abort partway through a long dwell.
    cfg(32'd0, 32'd100, 32'd10, 16'd3, 2'd1);
    pt(32'd0, 3, 0, 0);
    push(32'd10, 1, 1, 0, 0, 0);
    push(32'd10, 0, 1, 0, 0, 0);
    launch("dwell_abort");
    drain("dwell_abort");
    bus.abort = 1'b1;
    push(32'd10, 0, 0, 0, 0, 0);
    tick();
    chk("dwell_abort_drop");
    bus.abort = 1'b0;
    push(32'd10, 0, 0, 0, 0, 0);
    tick();
    chk("dwell_abort_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddfs_sweep_ctrl.md
# ddfs_sweep_ctrl

Frequency-sweep scheduler for the DDFS phase accumulator. It programs the accumulator's frequency tuning word (FTW) as a stepped linear chirp between two programmed FTWs, holding each point for a programmable dwell. It supports single-shot, continuous-sawtooth and up-down (triangle) sweep modes, with a start/abort handshake. It sits between the configuration source and the phase-accumulator FTW register, which feeds the sine, triangle and PWM generators.

## Interface
- FTW_W, 32, tuning-word width (matches phase accumulator)
- DWELL_W, 16, dwell counter width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1
- abort  in  1  stop the sweep immediately; has priority over start
- mode  in  2  0 single, 1 continuous sawtooth, 2 up-down, 3 treated as single
- ftw_start  in  FTW_W  first sweep point
- ftw_stop  in  FTW_W  last sweep point
- ftw_step  in  FTW_W  increment between points
- dwell  in  DWELL_W  each point is held dwell+1 cycles
- ftw_out  out  FTW_W  current tuning word to the phase accumulator
- ftw_load  out  1  one-cycle strobe; high in the first cycle of every new point
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at the end of a single sweep
- wrap  out  1  one-cycle pulse on each continuous reload or up-down turn
- dir  out  1  0 ascending, 1 descending

## Operation
- States:
  - IDLE: busy=0, ftw_out holds its last value.
  - DWELL: ftw_out is held while the dwell counter runs.
  - STEP: computes the next point. STEP is internal and takes zero output cycles; the next point appears directly after the dwell expires.
- IDLE + start (with abort=0):
  - mode, ftw_start, ftw_stop, ftw_step and dwell are latched into shadow registers.
  - Input changes are ignored until the next start.
  - Go to DWELL with ftw_out=ftw_start, dir=0.
- Step arithmetic uses FTW_W+1 bits:
  - Ascending: next = cur + step. If next ≥ stop (including carry-out), next = stop; this is the top point.
  - Descending: next = cur − step. If the borrow is set or next ≤ start, next = start; this is the bottom point.
- End of the dwell at the top point, by mode:
  - Single: go to IDLE with done=1; ftw_out stays at stop.
  - Continuous: next point is ftw_start, wrap=1.
  - Up-down: dir=1 and the sweep descends; the top point is not repeated.
- End of the dwell at the bottom point while descending (up-down mode): dir=0, wrap=1, and the sweep ascends again.
- Degenerate config (ftw_start ≥ ftw_stop, or ftw_step=0): ftw_start is output for one dwell, then the block goes to IDLE with done=1, in every mode.
- abort in any state: IDLE next cycle, busy=0, ftw_out frozen, no done, dir cleared.
- start while busy: ignored, with no effect on the shadow registers.
- Reset values: ftw_out=0, ftw_load=0, busy=0, done=0, wrap=0, dir=0, state IDLE, dwell counter 0. Reset mid-sweep returns all of these next edge.

## Timing
- start is sampled at edge E. At E+1: busy=1, ftw_out=ftw_start, ftw_load=1.
- Each point occupies exactly dwell+1 cycles. ftw_load is high only in the first of them, even if the new value equals the old one.
- The end pulses (done, wrap) are high in the same cycle as the first cycle of the following state/point. At the end of a single sweep, done=1 and busy=0 in the same cycle.
- There is no idle gap between points or across a wrap/turn.
- abort sampled at edge A: busy=0 at A+1, ftw_load=0 from A+1.
- A start in the same cycle as done (block already IDLE) is accepted.

## Test plan
- Single sweep: start=0, stop=10, step=4, dwell=1, mode=0, start at edge 0.
  - Required: ftw_out 0 at cycles 1–2, 4 at 3–4, 8 at 5–6, 10 at 7–8.
  - ftw_load at cycles 1, 3, 5, 7; done=1 and busy=0 at cycle 9.
- Continuous: start=0, stop=8, step=4, dwell=0, mode=1.
  - Required: sequence 0, 4, 8, 0, 4, 8…, one point per cycle, with wrap on each return to 0.
- Up-down: same config with mode=2.
  - Required: 0, 4, 8, 4, 0, 4, 8…; dir rises with the first 4 after 8; wrap at each turn at 8 and at 0; endpoints never repeated.
- Overflow/saturation: FTW_W=32, start=0xFFFF_FFF0, stop=0xFFFF_FFFF, step=0x20.
  - Required: points 0xFFFF_FFF0, then 0xFFFF_FFFF, then done.
- Degenerate config: start=5, stop=5, dwell=3.
  - Required: ftw_out=5 for 4 cycles, then done in every mode.
- Abort, reset and re-start:
  - abort during dwell: busy drops next cycle, ftw_out frozen, no done.
  - start in the same cycle as abort: ignored.
  - reset mid-sweep: all outputs are 0 next cycle.
  - Changing inputs while busy does not alter the running sweep.
